dense_layer_seq: RTL and testbench
==================================

# dense_layer_seq

Parametrised, time-multiplexed fully-connected layer for the 1-D CNN datapath. It generalises the fixed two-input network to N_IN inputs and N_OUT neurons with runtime-loadable weights and biases, a selectable activation and valid/ready handshakes. A single signed multiply-accumulate unit is shared across all weights, so layers can be chained between convolution stages or stacked into small MLPs.

## Interface
- DATA_WIDTH, 12: signed fixed-point word width for inputs, weights, biases and outputs.
- FRAC_BITS, 9: fractional bits, so 1.0 = 512 at the defaults.
- N_IN, 2: input vector length (≥1).
- N_OUT, 2: neuron count (≥1).
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_we  in  1  parameter write strobe.
- cfg_addr  in  $clog2(N_OUT*(N_IN+1))  address = j*(N_IN+1)+i. i<N_IN selects weight w[j][i]; i=N_IN selects bias b[j].
- cfg_data  in  DATA_WIDTH  parameter value.
- act_sel  in  2  activation select: 0 identity, 1 ReLU, 2 hard-sigmoid, 3 reserved (acts as identity).
- in_valid  in  1  input vector valid.
- in_ready  out  1  high only in IDLE.
- in_data  in  N_IN*DATA_WIDTH  element i at [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  result vector valid.
- out_ready  in  1  downstream accept.
- out_data  out  N_OUT*DATA_WIDTH  neuron j at [j*DATA_WIDTH +: DATA_WIDTH].
- busy  out  1  high in ACC and DONE.

## Operation
- **State machine: IDLE → ACC → DONE → IDLE.**
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data and act_sel, set j=0, i=0, load acc = sext(b[0])<<FRAC_BITS, then go to ACC.
- **ACC**, one product per cycle: acc += w[j][i]*x[i], full-precision signed.
  - Accumulator width: 2*DATA_WIDTH + $clog2(N_IN+1). It never overflows internally.
  - In the cycle where i==N_IN-1, the final sum s = acc + product is post-processed and written to out_data slot j.
  - Then, if j==N_OUT-1, go to DONE. Otherwise j++, i=0, acc = sext(b[j+1])<<FRAC_BITS.
- **Post-processing**
  - y = s >>> FRAC_BITS (arithmetic shift, floor rounding).
  - Activation is applied to y before saturation:
    - identity: y.
    - ReLU: max(y,0).
    - hard-sigmoid: clamp((y>>>2) + 2^(FRAC_BITS-1), 0, 2^FRAC_BITS).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- **DONE**
  - out_valid=1.
  - out_data is held stable until out_valid&&out_ready, then return to IDLE.
  - out_valid drops on the edge of acceptance.
- **Config writes**
  - Accepted only in IDLE.
  - cfg_we in ACC or DONE is ignored; in-flight vectors always use the weights present at input handshake.
  - Addresses ≥ N_OUT*(N_IN+1) are ignored.
  - A write in the same cycle as an input handshake is applied before the first ACC read.
- **Reset (rst low, any state, including mid-ACC)**
  - State → IDLE; all weights, biases, out_data and acc → 0; out_valid=0; busy=0; in_ready=1.
  - Partial results are discarded.
  - in_valid is not accepted while rst is low.

## Timing
- Input handshake at edge T.
- out_valid rises after edge T+N_IN*N_OUT (2×2 default: 4 cycles).
- Minimum spacing between input handshakes: N_IN*N_OUT+2 cycles, i.e. one IDLE cycle plus one DONE cycle with out_ready held high.
- There is no input/output overlap: in_ready=0 throughout ACC and DONE.
- in_ready and busy are decoded from state. out_valid and out_data are registered.
- Config write at edge T is visible to a handshake at edge T+1 or later, and to a same-edge handshake as stated above.

## Test plan
- **XOR hidden layer** (defaults): w[0]={512,512}, b0=0; w[1]={512,512}, b1=-512; ReLU.
  - Inputs {0,0} → {0,0}.
  - {512,0} → {512,0}.
  - {512,512} → {1024,512}.
  - out_valid exactly 4 cycles after each handshake.
- **Saturation/rounding**, identity, all weights 2047:
  - x={2047,2047} → both outputs 2047.
  - x={-2048,2047} → 2047·(-2048+2047)/512 = -3.998 → floor → -4.
  - Weights -2048 with x={2047,2047} → -2048.
- **Hard-sigmoid**, w[0]={512,0}, b0=0:
  - x0=0 → 256.
  - x0=1024 → 512.
  - x0=-1024 → 0.
  - x0=2047 → 512 (clamped).
- **Backpressure**: hold out_ready=0 for 10 cycles in DONE.
  - out_valid stays 1 and out_data does not change.
  - in_ready=0, and in_valid is ignored.
  - Raise out_ready → handshake, IDLE next cycle, new vector accepted.
- **Config gating**: write w[0][0]=1024 while busy → ignored. Result uses old weight 512. The same write in IDLE takes effect on the next vector.
- **Reset mid-ACC**: assert rst low at cycle 2 of ACC.
  - Immediately out_valid=0, busy=0, out_data=0.
  - After release, a vector with zeroed weights gives all outputs 0 (identity), or 256 with hard-sigmoid.

Source files
------------

// File: rtl/dense_layer_seq.sv
// dense_layer_seq
// Time-multiplexed fully-connected layer. One signed multiply-accumulate unit
// walks every weight of every neuron, one product per cycle. Weights and biases
// are held in a small register file that can be written only while idle. The
// result vector is handed downstream over a valid/ready handshake.
module dense_layer_seq #(
  parameter int DATA_WIDTH = 12,
  parameter int FRAC_BITS  = 9,
  parameter int N_IN       = 2,
  parameter int N_OUT      = 2,
  localparam int N_PARAM   = N_OUT * (N_IN + 1),
  localparam int ADDR_W    = $clog2(N_PARAM)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [ADDR_W-1:0]             cfg_addr,
  input  logic [DATA_WIDTH-1:0]         cfg_data,
  input  logic [1:0]                    act_sel,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_IN*DATA_WIDTH-1:0]    in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_OUT*DATA_WIDTH-1:0]   out_data,
  output logic                          busy
);

  // Accumulator is wide enough for N_IN full products plus the shifted bias.
  localparam int ACC_W  = 2 * DATA_WIDTH + $clog2(N_IN + 1);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int IW     = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic signed [ACC_W-1:0] ONE_A   = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] FX_ONE  = ONE_A <<< FRAC_BITS;
  localparam logic signed [ACC_W-1:0] FX_HALF = ONE_A <<< (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ONE_A <<< (DATA_WIDTH - 1)) - ONE_A;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ONE_A <<< (DATA_WIDTH - 1));

  localparam logic [ADDR_W:0] N_PARAM_C = (ADDR_W + 1)'(N_PARAM);
  localparam logic [IW-1:0]   I_LAST    = IW'(N_IN - 1);
  localparam logic [JW-1:0]   J_LAST    = JW'(N_OUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Register-file address of weight w[j][i].
  function automatic logic [ADDR_W-1:0] weight_idx(input logic [JW-1:0] j,
                                                   input logic [IW-1:0] i);
    return ADDR_W'(j) * ADDR_W'(N_IN + 1) + ADDR_W'(i);
  endfunction

  // Register-file address of bias b[j]; it follows the row's weights.
  function automatic logic [ADDR_W-1:0] bias_idx(input logic [JW-1:0] j);
    return ADDR_W'(j) * ADDR_W'(N_IN + 1) + ADDR_W'(N_IN);
  endfunction

  // Bias aligned to the product scale (2*FRAC_BITS fractional bits).
  function automatic logic signed [ACC_W-1:0] bias_fx(input logic signed [DATA_WIDTH-1:0] b);
    return ACC_W'(b) <<< FRAC_BITS;
  endfunction

  // Rescale a finished sum, apply the activation, then saturate to a word.
  function automatic logic [DATA_WIDTH-1:0] post_proc(input logic signed [ACC_W-1:0] s,
                                                      input logic [1:0] act);
    logic signed [ACC_W-1:0] y;
    logic signed [ACC_W-1:0] h;
    logic signed [ACC_W-1:0] a;
    logic signed [ACC_W-1:0] r;
    y = s >>> FRAC_BITS;
    h = (y >>> 2'd2) + FX_HALF;
    case (act)
      2'd1: begin
        a = y[ACC_W-1] ? '0 : y;
      end
      2'd2: begin
        if (h[ACC_W-1]) begin
          a = '0;
        end else if (h > FX_ONE) begin
          a = FX_ONE;
        end else begin
          a = h;
        end
      end
      default: begin
        a = y;
      end
    endcase
    if (a > SAT_MAX) begin
      r = SAT_MAX;
    end else if (a < SAT_MIN) begin
      r = SAT_MIN;
    end else begin
      r = a;
    end
    return r[DATA_WIDTH-1:0];
  endfunction

  state_t                           state_q, state_d;
  logic [IW-1:0]                    i_q, i_d;
  logic [JW-1:0]                    j_q, j_d;
  logic signed [ACC_W-1:0]          acc_q, acc_d;
  logic [N_IN*DATA_WIDTH-1:0]       x_q, x_d;
  logic [1:0]                       act_q, act_d;
  logic signed [DATA_WIDTH-1:0]     param_q [N_PARAM];
  logic signed [DATA_WIDTH-1:0]     param_d [N_PARAM];
  logic [N_OUT*DATA_WIDTH-1:0]      out_q, out_d;
  logic                             out_valid_q, out_valid_d;

  logic signed [DATA_WIDTH-1:0]     w_sel_s;
  logic signed [DATA_WIDTH-1:0]     x_sel_s;
  logic signed [PROD_W-1:0]         prod_s;
  logic signed [ACC_W-1:0]          sum_s;
  logic [DATA_WIDTH-1:0]            y_post_s;

  // Shared MAC datapath: current weight times current input plus accumulator.
  always_comb begin
    w_sel_s  = param_q[weight_idx(j_q, i_q)];
    x_sel_s  = x_q[i_q*DATA_WIDTH +: DATA_WIDTH];
    prod_s   = PROD_W'(w_sel_s) * PROD_W'(x_sel_s);
    sum_s    = acc_q + ACC_W'(prod_s);
    y_post_s = post_proc(sum_s, act_q);
  end

  // Next-state logic for the sequencer, parameter file and result registers.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    acc_d       = acc_q;
    x_d         = x_q;
    act_d       = act_q;
    param_d     = param_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        // Parameter writes land first so a same-cycle input sees them,
        // including the bias loaded below.
        if (cfg_we && ({1'b0, cfg_addr} < N_PARAM_C)) begin
          param_d[cfg_addr] = cfg_data;
        end else begin
          param_d = param_q;
        end
        if (in_valid) begin
          x_d     = in_data;
          act_d   = act_sel;
          i_d     = '0;
          j_d     = '0;
          acc_d   = bias_fx(param_d[bias_idx('0)]);
          state_d = S_ACC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        if (i_q == I_LAST) begin
          out_d[j_q*DATA_WIDTH +: DATA_WIDTH] = y_post_s;
          if (j_q == J_LAST) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end else begin
            j_d   = j_q + 1'b1;
            i_d   = '0;
            acc_d = bias_fx(param_q[bias_idx(j_q + 1'b1)]);
          end
        end else begin
          i_d   = i_q + 1'b1;
          acc_d = sum_s;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d     = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset clears weights, results and any partial sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      act_q       <= '0;
      param_q     <= '{default: '0};
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      act_q       <= act_d;
      param_q     <= param_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_ACC) || (state_q == S_DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: directed vectors with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_dense_layer_seq;

  localparam int DW = 12;
  localparam int F  = 9;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int NP = NO * (NI + 1);
  localparam int AW = $clog2(NP);

  logic              clk;
  logic              rst;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [DW-1:0]     cfg_data;
  logic [1:0]        act_sel;
  logic              in_valid;
  logic              in_ready;
  logic [NI*DW-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [NO*DW-1:0]  out_data;
  logic              busy;

  int checks = 0;
  int errors = 0;

  dense_layer_seq #(
    .DATA_WIDTH(DW), .FRAC_BITS(F), .N_IN(NI), .N_OUT(NO)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .act_sel(act_sel), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  int mp    [NP];
  int m_out [NO];
  int m_x   [NI];
  int m_act = 0;
  int m_cnt = 0;
  int m_st  = 0;      // 0 idle, 1 computing, 2 holding result
  bit m_valid = 1'b0;
  bit m_known = 1'b1; // out_data has a defined value right now

  function automatic int slot(input int j);
    return int'($signed(out_data[j*DW +: DW]));
  endfunction

  initial begin
    for (int k = 0; k < NP; k++) mp[k] = 0;
    for (int k = 0; k < NO; k++) m_out[k] = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int k = 0; k < NP; k++) mp[k] = 0;
        for (int k = 0; k < NO; k++) m_out[k] = 0;
        m_st = 0; m_valid = 1'b0; m_known = 1'b1; m_cnt = 0;
      end else if (m_st == 0) begin
        if (cfg_we && int'(cfg_addr) < NP) mp[int'(cfg_addr)] = int'($signed(cfg_data));
        if (in_valid) begin
          for (int i = 0; i < NI; i++) m_x[i] = int'($signed(in_data[i*DW +: DW]));
          m_act = int'(act_sel);
          for (int j = 0; j < NO; j++) begin
            longint s;
            longint y;
            s = longint'(mp[j*(NI+1)+NI]) * (64'sd1 <<< F);
            for (int i = 0; i < NI; i++) s = s + longint'(mp[j*(NI+1)+i]) * longint'(m_x[i]);
            y = s >>> F;
            if (m_act == 1) begin
              if (y < 0) y = 0;
            end else if (m_act == 2) begin
              y = (y >>> 2) + (64'sd1 <<< (F - 1));
              if (y < 0) y = 0;
              else if (y > (64'sd1 <<< F)) y = 64'sd1 <<< F;
            end
            if (y > (64'sd1 <<< (DW - 1)) - 1) y = (64'sd1 <<< (DW - 1)) - 1;
            if (y < -(64'sd1 <<< (DW - 1))) y = -(64'sd1 <<< (DW - 1));
            m_out[j] = int'(y);
          end
          m_st = 1; m_cnt = NI * NO; m_known = 1'b0;
        end
      end else if (m_st == 1) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_st = 2; m_valid = 1'b1; m_known = 1'b1;
        end
      end else begin
        if (out_ready) begin
          m_st = 0; m_valid = 1'b0; m_known = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, m_valid);
    end
    checks++;
    if (in_ready !== (m_st == 0)) begin
      errors++;
      $display("FAIL in_ready @%0t: got %b expected %b", $time, in_ready, (m_st == 0));
    end
    checks++;
    if (busy !== (m_st != 0)) begin
      errors++;
      $display("FAIL busy @%0t: got %b expected %b", $time, busy, (m_st != 0));
    end
    if (m_known) begin
      for (int j = 0; j < NO; j++) begin
        checks++;
        if (slot(j) != m_out[j]) begin
          errors++;
          $display("FAIL out_data[%0d] @%0t: got %0d expected %0d", j, $time, slot(j), m_out[j]);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_data = DW'(d);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic send(input int x0, input int x1, input int a);
    chk("send_in_ready", int'(in_ready), 1);
    in_data  = {DW'(x1), DW'(x0)};
    act_sel  = 2'(a);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wait_out timeout: got no out_valid expected out_valid within 50 cycles");
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("accept_out_valid", int'(out_valid), 0);
    chk("accept_in_ready", int'(in_ready), 1);
  endtask

  task automatic vec(input string nm, input int x0, input int x1, input int a,
                     input int e0, input int e1);
    int lat;
    send(x0, x1, a);
    wait_out(lat);
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_y0"}, slot(0), e0);
    chk({nm, "_y1"}, slot(1), e1);
    accept();
  endtask

  function automatic int rnd_word();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 4095)) - 2048;
    else return int'($urandom_range(0, 1200)) - 600;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int h0, h1;
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; act_sel = 2'd0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_y0", slot(0), 0);
    #2 rst = 1'b1;
    @(negedge clk);

    // XOR hidden layer, ReLU
    cfg_write(0, 512); cfg_write(1, 512); cfg_write(2, 0);
    cfg_write(3, 512); cfg_write(4, 512); cfg_write(5, -512);
    vec("xor00", 0, 0, 1, 0, 0);
    vec("xor10", 512, 0, 1, 512, 0);
    vec("xor11", 512, 512, 1, 1024, 512);

    // Saturation and floor rounding, identity
    cfg_write(0, 2047); cfg_write(1, 2047); cfg_write(2, 0);
    cfg_write(3, 2047); cfg_write(4, 2047); cfg_write(5, 0);
    vec("sat_pos", 2047, 2047, 0, 2047, 2047);
    vec("floor", -2048, 2047, 0, -4, -4);
    cfg_write(0, -2048); cfg_write(1, -2048); cfg_write(3, -2048); cfg_write(4, -2048);
    vec("sat_neg", 2047, 2047, 0, -2048, -2048);

    // Hard-sigmoid
    cfg_write(0, 512); cfg_write(1, 0); cfg_write(2, 0);
    cfg_write(3, 0); cfg_write(4, 0); cfg_write(5, 0);
    vec("hs_0", 0, 0, 2, 256, 256);
    vec("hs_1024", 1024, 0, 2, 512, 256);
    vec("hs_m1024", -1024, 0, 2, 0, 256);
    vec("hs_clamp", 2047, 0, 2, 512, 256);

    // Backpressure: result held for 10 cycles, inputs ignored meanwhile
    send(1024, 0, 2);
    wait_out(lat);
    h0 = slot(0); h1 = slot(1);
    chk("bp_y0", h0, 512);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = {DW'(rnd_word()), DW'(rnd_word())};
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_hold0", slot(0), h0);
      chk("bp_hold1", slot(1), h1);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    accept();
    vec("bp_next", 0, 0, 2, 256, 256);

    // Config writes are ignored while busy
    cfg_write(0, 512); cfg_write(1, 512); cfg_write(2, 0);
    cfg_write(3, 512); cfg_write(4, 512); cfg_write(5, -512);
    send(512, 0, 0);
    chk("gate_busy", int'(busy), 1);
    cfg_write(0, 1024);
    wait_out(lat);
    chk("gate_old_y0", slot(0), 512);
    chk("gate_old_y1", slot(1), 0);
    accept();
    cfg_write(0, 1024);
    vec("gate_new", 512, 0, 0, 1024, 0);

    // Reset in the middle of accumulation
    send(512, 512, 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_y0", slot(0), 0);
    chk("mid_rst_y1", slot(1), 0);
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    vec("zero_id", 512, 512, 0, 0, 0);
    vec("zero_hs", 512, 512, 2, 256, 256);

    // Randomized traffic, checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = AW'($urandom_range(0, 7));
      cfg_data  = DW'(rnd_word());
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = {DW'(rnd_word()), DW'(rnd_word())};
      act_sel   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
